id_ex_hazard_stage: RTL and testbench
=====================================

Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register combined with load-use hazard detection for the 5-stage RV32 pipeline.
- Captures decoded operands and control from the ID stage each cycle.
- Inserts a one-cycle bubble when the instruction in EX is a load whose rd is read by the instruction in ID.
- Squashes on branch/jump redirect. Its registered rs1/rs2/rd fields are what the EX-stage forwarding logic compares against EX/MEM and MEM/WB destinations.

Parameters:
XLEN, 32, datapath width (PC, register data, immediate)
CTRL_W, 8, width of opaque EX/MEM/WB control bundle passed through unchanged
CNT_W, 16, width of saturating stall/flush event counters

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  branch/jump taken resolved downstream; squash ID
id_valid  input  1  IF/ID holds a real instruction
id_pc  input  XLEN  PC of ID instruction
id_rs1  input  5  source register 1 index
id_rs2  input  5  source register 2 index
id_rs1_used  input  1  instruction actually reads rs1
id_rs2_used  input  1  instruction actually reads rs2
id_rd  input  5  destination register index
id_rdata1  input  XLEN  register file read data 1
id_rdata2  input  XLEN  register file read data 2
id_imm  input  XLEN  sign-extended immediate
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load
id_ctrl  input  CTRL_W  remaining control bundle
pc_write  output  1  0 = hold PC this cycle
ifid_write  output  1  0 = hold IF/ID this cycle
ex_valid  output  1  registered valid
ex_pc, ex_rdata1, ex_rdata2, ex_imm  output  XLEN each  registered
ex_rs1, ex_rs2, ex_rd  output  5 each  registered, fed to forwarding comparison
ex_reg_write, ex_mem_read  output  1 each  registered
ex_ctrl  output  CTRL_W  registered
stall_cnt  output  CNT_W  load-use bubbles inserted, saturating
flush_cnt  output  CNT_W  flush bubbles inserted, saturating

Behaviour:
- Reset (rst=1 at edge): all ex_* outputs and both counters are 0. pc_write=ifid_write=1 follow combinationally from the cleared state. Reset mid-stall/mid-flush discards the pending bubble; the next cycle is a plain bubble-free state.
- Hazard (combinational): hz = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- pc_write = ifid_write = ~hz | flush. Flush overrides the hold so the redirect target is fetched.
- Register update priority per edge:
  - rst: clear everything.
  - flush: load bubble (ex_valid, ex_reg_write, ex_mem_read, ex_ctrl = 0; data/index fields don't-care but driven 0); flush_cnt++.
  - hz: load bubble; stall_cnt++.
  - else: load all id_* fields with ex_valid=id_valid. If id_valid=0, force ex_reg_write=ex_mem_read=ex_ctrl=0.
- Latency: ID → EX is 1 cycle.
- Load-use penalty is exactly 1 cycle. The bubble has ex_mem_read=0, so hz deasserts the next cycle and the held ID instruction advances.
- rd/rs index 0 never causes a hazard.
- Simultaneous hz and flush: flush wins. Only flush_cnt increments; PC is not held.
- Counters saturate at all-ones; no wrap.
- Back-to-back load then dependent load: each dependent load costs 1 bubble independently.
- No combinational path from id_* data inputs to any ex_* output.

Decomposition:
- Shared pipeline package holds:
  - REG_IDX_W=5 and XLEN.
  - Control bundle bit positions for the CTRL_W field.
  - Constant BUBBLE_CTRL ('0).
- One natural sub-module: load_use_detect, the combinational hz equation. It keeps the stall condition separately testable from the register.
- Counters stay inline.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5); ID reads rs1=5 with rs1_used=1 → pc_write=ifid_write=0 that cycle. Next cycle ex_valid=0, stall_cnt=1. Following cycle ID instruction appears in EX with ex_rs1=5.
- Same as above but id_rs2=5 with id_rs2_used=0 (I-type) → no stall, pc_write=1, stall_cnt stays 0.
- Load with ex_rd=0 and ID rs1=0 → no stall. Non-load (ex_mem_read=0) with ex_rd=5, ID rs1=5 → no stall; forwarding handles it.
- hz and flush asserted together → pc_write=1, next ex_valid=0, flush_cnt=1, stall_cnt=0.
- Stream of 8 independent valid instructions → ex_* equals previous-cycle id_* every cycle, zero bubbles, both counters 0.
- Force stall_cnt to all-ones (CNT_W=4 build, 16 load-use events) → stall_cnt holds 15. rst asserted during a hazard → all ex_* 0 and counters 0 next cycle.

Source files
------------

// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared RV32 pipeline constants: register index width, datapath width and the
// bit layout of the opaque EX/MEM/WB control bundle.
package id_ex_hazard_stage_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int CTRL_W    = 8;

  // Control bundle layout; this stage passes it through without decoding it
  localparam int CTRL_ALU_SRC    = 0;
  localparam int CTRL_ALU_OP_LSB = 1;
  localparam int CTRL_ALU_OP_MSB = 4;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_BRANCH     = 7;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_hazard_stage_load_use_detect.sv
// Load-use hazard detect: the EX instruction is a load whose rd is read by the
// instruction sitting in ID. x0 never matches.
module load_use_detect
  import id_ex_hazard_stage_pkg::*;
(
  input  logic                 ex_valid,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  output logic                 hz
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);

  assign hz = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid
              && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and
// saturating stall/flush event counters.
module id_ex_hazard_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rdata1,
  input  logic [XLEN-1:0]   id_rdata2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rdata1,
  output logic [XLEN-1:0]   ex_rdata2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  import id_ex_hazard_stage_pkg::*;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rdata1;
    logic [XLEN-1:0]      rdata2;
    logic [XLEN-1:0]      imm;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
    logic                 mem_read;
    logic [CTRL_W-1:0]    ctrl;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d;
  logic    hz;
  logic    stall_evt;

  load_use_detect u_lud (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.mem_read),
    .ex_rd       (ex_q.rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .hz          (hz)
  );

  // Flush must not hold the front end, or the redirect target would be lost
  assign pc_write   = ~hz | flush;
  assign ifid_write = ~hz | flush;
  assign stall_evt  = hz & ~flush;

  always_comb begin
    ex_d      = '0;
    ex_d.ctrl = CTRL_W'(BUBBLE_CTRL);
    if (!flush && !hz) begin
      ex_d.valid  = id_valid;
      ex_d.pc     = id_pc;
      ex_d.rdata1 = id_rdata1;
      ex_d.rdata2 = id_rdata2;
      ex_d.imm    = id_imm;
      ex_d.rs1    = id_rs1;
      ex_d.rs2    = id_rs2;
      ex_d.rd     = id_rd;
      // An invalid slot must never write state downstream
      if (id_valid) begin
        ex_d.reg_write = id_reg_write;
        ex_d.mem_read  = id_mem_read;
        ex_d.ctrl      = id_ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex_q <= ex_d;
      if (flush && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (stall_evt && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rdata1    = ex_q.rdata1;
  assign ex_rdata2    = ex_q.rdata2;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_ctrl      = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: each stimulus row pushes the outputs
// expected in that cycle; a monitor pops and compares every cycle.
module tb_id_ex_hazard_stage;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_rs1_used, id_rs2_used;
  logic [31:0] id_pc, id_rdata1, id_rdata2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_reg_write, id_mem_read;
  logic [7:0]  id_ctrl;
  logic        pc_write, ifid_write, ex_valid, ex_reg_write, ex_mem_read;
  logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [7:0]  ex_ctrl;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(.XLEN(32), .CTRL_W(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rdata1(id_rdata1),
    .id_rdata2(id_rdata2), .id_imm(id_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_ctrl(id_ctrl), .pc_write(pc_write),
    .ifid_write(ifid_write), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, mr, rw;
    logic [7:0]  ctrl;
  } ins_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        mr, rw;
    logic [7:0]  ctrl;
  } st_t;

  typedef struct {
    string      tag;
    logic       pw;
    st_t        st;
    logic [3:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam ins_t NOP = '0;
  localparam st_t  Z   = '0;

  function automatic ins_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                              input logic u1, input logic [4:0] rs2, input logic u2,
                              input logic [4:0] rd, input logic mr, input logic [7:0] ctrl);
    ins_t i;
    i = '{valid:1'b1, pc:pc, rs1:rs1, rs2:rs2, rd:rd, u1:u1, u2:u2, mr:mr, rw:1'b1, ctrl:ctrl};
    return i;
  endfunction

  // A valid instruction shows up in EX unchanged one cycle later
  function automatic st_t to_st(input ins_t i);
    st_t s;
    s = '{valid:i.valid, pc:i.pc, rs1:i.rs1, rs2:i.rs2, rd:i.rd, mr:i.mr, rw:i.rw, ctrl:i.ctrl};
    return s;
  endfunction

  function automatic logic [31:0] dat(input logic [31:0] pc, input logic [31:0] k);
    return (pc == 32'h0) ? 32'h0 : pc + k;
  endfunction

  task automatic step(input string tag, input logic r, input logic f, input ins_t i,
                      input logic pw, input st_t e, input int sc, input int fc);
    exp_t x;
    @(negedge clk);
    rst = r; flush = f;
    id_valid = i.valid; id_pc = i.pc; id_rs1 = i.rs1; id_rs2 = i.rs2;
    id_rs1_used = i.u1; id_rs2_used = i.u2; id_rd = i.rd;
    id_mem_read = i.mr; id_reg_write = i.rw; id_ctrl = i.ctrl;
    id_rdata1 = dat(i.pc, 32'd1); id_rdata2 = dat(i.pc, 32'd2); id_imm = dat(i.pc, 32'd3);
    x.tag = tag; x.pw = pw; x.st = e; x.sc = 4'(sc); x.fc = 4'(fc);
    q.push_back(x);
  endtask

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h want %0h", tag, nm, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.tag, "pc_write",   32'(pc_write),     32'(e.pw));
        chk(e.tag, "ifid_write", 32'(ifid_write),   32'(e.pw));
        chk(e.tag, "ex_valid",   32'(ex_valid),     32'(e.st.valid));
        chk(e.tag, "ex_pc",      ex_pc,             e.st.pc);
        chk(e.tag, "ex_rdata1",  ex_rdata1,         dat(e.st.pc, 32'd1));
        chk(e.tag, "ex_rdata2",  ex_rdata2,         dat(e.st.pc, 32'd2));
        chk(e.tag, "ex_imm",     ex_imm,            dat(e.st.pc, 32'd3));
        chk(e.tag, "ex_rs1",     32'(ex_rs1),       32'(e.st.rs1));
        chk(e.tag, "ex_rs2",     32'(ex_rs2),       32'(e.st.rs2));
        chk(e.tag, "ex_rd",      32'(ex_rd),        32'(e.st.rd));
        chk(e.tag, "ex_mem_read",32'(ex_mem_read),  32'(e.st.mr));
        chk(e.tag, "ex_reg_wr",  32'(ex_reg_write), 32'(e.st.rw));
        chk(e.tag, "ex_ctrl",    32'(ex_ctrl),      32'(e.st.ctrl));
        chk(e.tag, "stall_cnt",  32'(stall_cnt),    32'(e.sc));
        chk(e.tag, "flush_cnt",  32'(flush_cnt),    32'(e.fc));
      end
    end
  end

  initial begin : driver
    ins_t a, b, c, prev, n;
    st_t  pst;
    int   sc;
    rst = 1'b1; flush = 1'b0;
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rdata1 = 0; id_rdata2 = 0; id_imm = 0; id_reg_write = 0;
    id_mem_read = 0; id_ctrl = 0;
    @(posedge clk);

    step("rst",  1, 0, NOP, 1, Z, 0, 0);
    step("idle", 0, 0, NOP, 1, Z, 0, 0);

    // load x5 then dependent rs1: one bubble, then advance
    a = mk(32'h100, 1, 1, 0, 0, 5, 1, 8'h41); step("ld",     0, 0, a, 1, Z,        0, 0);
    b = mk(32'h104, 5, 1, 6, 1, 7, 0, 8'h02); step("hz_rs1", 0, 0, b, 0, to_st(a), 0, 0);
                                              step("bubble", 0, 0, b, 1, Z,        1, 0);
    c = mk(32'h108, 2, 1, 3, 1, 8, 0, 8'h02); step("adv",    0, 0, c, 1, to_st(b), 1, 0);

    // rs2 matches but is unused
    a = mk(32'h10c, 1, 1, 0, 0, 5, 1, 8'h41); step("ld2",    0, 0, a, 1, to_st(c), 1, 0);
    b = mk(32'h110, 6, 1, 5, 0, 9, 0, 8'h03); step("rs2_off",0, 0, b, 1, to_st(a), 1, 0);

    // x0 load and non-load producer never stall
    a = mk(32'h114, 1, 1, 0, 0, 0, 1, 8'h41); step("ld_x0",  0, 0, a, 1, to_st(b), 1, 0);
    b = mk(32'h118, 0, 1, 0, 1, 10, 0, 8'h02); step("rs_x0", 0, 0, b, 1, to_st(a), 1, 0);
    a = mk(32'h11c, 1, 1, 0, 0, 5, 0, 8'h02); step("alu_x5", 0, 0, a, 1, to_st(b), 1, 0);
    b = mk(32'h120, 5, 1, 5, 1, 11, 0, 8'h02); step("no_ld", 0, 0, b, 1, to_st(a), 1, 0);

    // hazard and flush together: flush wins, no hold
    a = mk(32'h124, 1, 1, 0, 0, 5, 1, 8'h41); step("ld3",    0, 0, a, 1, to_st(b), 1, 0);
    b = mk(32'h128, 5, 1, 0, 0, 12, 0, 8'h02); step("hz_fl", 0, 1, b, 1, to_st(a), 1, 0);
    c = mk(32'h200, 5, 1, 0, 0, 13, 0, 8'h02); step("target",0, 0, c, 1, Z,        1, 1);

    prev = c;
    for (int i = 0; i < 8; i++) begin
      a = mk(32'h204 + 32'(4*i), 5'(i+1), 1, 5'(i+9), 1, 5'(i+16), 0, 8'(i));
      step("stream", 0, 0, a, 1, to_st(prev), 1, 1);
      prev = a;
    end

    // invalid slot carrying stray control must not leak it
    n = NOP; n.mr = 1; n.rw = 1; n.ctrl = 8'hff;
    step("inv_ctl", 0, 0, n, 1, to_st(prev), 1, 1);

    // 16 load-use events saturate the 4-bit counter at 15
    pst = Z; sc = 1;
    for (int j = 0; j < 16; j++) begin
      a = mk(32'h300 + 32'(16*j), 1, 1, 0, 0, 5, 1, 8'h41);
      step("sat_ld", 0, 0, a, 1, pst, sc, 1);
      b = mk(32'h304 + 32'(16*j), 5, 1, 6, 1, 6, 0, 8'h02);
      step("sat_hz", 0, 0, b, 0, to_st(a), sc, 1);
      sc = (sc < 15) ? sc + 1 : 15;
      step("sat_bub", 0, 0, b, 1, Z, sc, 1);
      pst = to_st(b);
    end

    // reset during a hazard drops the pending bubble
    a = mk(32'h400, 1, 1, 0, 0, 5, 1, 8'h41); step("r_ld",  0, 0, a, 1, pst,      15, 1);
    b = mk(32'h404, 5, 1, 0, 0, 6, 0, 8'h02); step("r_hz",  1, 0, b, 0, to_st(a), 15, 1);
    step("post_rst", 0, 0, b,   1, Z,        0, 0);
    step("r_adv",    0, 0, NOP, 1, to_st(b), 0, 0);
    step("end",      0, 0, NOP, 1, Z,        0, 0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
